// File: rtl/perf_pkg.sv
// Shared constants and types for the performance-counter frame reader.
// PERF_READER_CHECKSUM_EN adds the trailing XOR checksum byte and its FSM state.
package perf_pkg;

   localparam int         DEFAULT_NUM_COUNTERS = 18;
   localparam int         DEFAULT_COUNT_W      = 32;
   localparam logic [7:0] HEADER_BYTE          = 8'hA5;

`ifdef PERF_READER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HEADER, DATA, CKSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif

   typedef enum logic [4:0] {
      CNT_ADD, CNT_SUB, CNT_ADDI, CNT_ADD_FP, CNT_MUL_FP, CNT_VADD_FP,
      CNT_VMUL_FP, CNT_VSUM_FP, CNT_VSET_FP, CNT_SW, CNT_LW, CNT_SW_FP,
      CNT_LW_FP, CNT_VST, CNT_VLD, CNT_BEQ, CNT_BLT, CNT_J
   } counter_t;

   // Counter width for an index range of n values, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/perf_byte_sel.sv
// Combinational pick of byte byte_num (LSB first) of counter idx from the snapshot.
// Out-of-range positions read as zero.
module perf_byte_sel
   import perf_pkg::*;
#(
   parameter int NUM_COUNTERS = DEFAULT_NUM_COUNTERS,
   parameter int COUNT_W      = DEFAULT_COUNT_W,
   parameter int IDX_W        = clog2_min1(NUM_COUNTERS),
   parameter int BYTE_W       = clog2_min1(COUNT_W / 8)
) (
   input  logic [NUM_COUNTERS*COUNT_W-1:0] snapshot,
   input  logic [IDX_W-1:0]                idx,
   input  logic [BYTE_W-1:0]               byte_num,
   output logic [7:0]                      sel_byte
);

   localparam int BYTES = COUNT_W / 8;

   // NOTE: default assignment first so every path drives sel_byte and no latch is inferred.
   always_comb begin
      sel_byte = 8'h00;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         for (int b = 0; b < BYTES; b++) begin
            if (idx == IDX_W'(i) && byte_num == BYTE_W'(b))
               sel_byte = snapshot[i*COUNT_W + b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/perf_counter_reader.sv
// Captures all counters on snapshot_req and streams them as a byte frame:
// header 0xA5, counter bytes LSB first, then an XOR checksum when PERF_READER_CHECKSUM_EN is defined.
module perf_counter_reader
   import perf_pkg::*;
#(
   parameter int NUM_COUNTERS = DEFAULT_NUM_COUNTERS,
   parameter int COUNT_W      = DEFAULT_COUNT_W
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_COUNTERS*COUNT_W-1:0] count_in,
   input  logic                            snapshot_req,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [7:0]                      out_data,
   output logic                            out_last,
   output logic                            busy,
   output logic                            overrun
);

   localparam int                BYTES     = COUNT_W / 8;
   localparam int                IDX_W     = clog2_min1(NUM_COUNTERS);
   localparam int                BYTE_W    = clog2_min1(BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_COUNTERS - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

   state_t                          state;
   logic [NUM_COUNTERS*COUNT_W-1:0] snapshot;
   logic [IDX_W-1:0]                idx;
   logic [IDX_W-1:0]                nxt_idx;
   logic [BYTE_W-1:0]               byte_num;
   logic [BYTE_W-1:0]               nxt_byte;
   logic [7:0]                      nxt_data;
   logic                            nxt_last;
   logic                            xfer;
   logic                            last_data;
`ifdef PERF_READER_CHECKSUM_EN
   logic [7:0]                      checksum;
`endif

   assign xfer      = out_valid && out_ready;
   assign last_data = (idx == LAST_IDX) && (byte_num == LAST_BYTE);
   assign busy      = (state != IDLE);

   // Address of the byte to present once the current one transfers; outputs stay registered.
   always_comb begin
      nxt_idx  = '0;
      nxt_byte = '0;
      if (state == DATA) begin
         if (byte_num == LAST_BYTE) begin
            nxt_idx = idx + IDX_W'(1);
         end else begin
            nxt_idx  = idx;
            nxt_byte = byte_num + BYTE_W'(1);
         end
      end
   end

`ifdef PERF_READER_CHECKSUM_EN
   assign nxt_last = 1'b0;
`else
   assign nxt_last = (nxt_idx == LAST_IDX) && (nxt_byte == LAST_BYTE);
`endif

   perf_byte_sel #(
      .NUM_COUNTERS (NUM_COUNTERS),
      .COUNT_W      (COUNT_W),
      .IDX_W        (IDX_W),
      .BYTE_W       (BYTE_W)
   ) u_byte_sel (
      .snapshot (snapshot),
      .idx      (nxt_idx),
      .byte_num (nxt_byte),
      .sel_byte (nxt_data)
   );

   // NOTE: sequential state uses non-blocking assignments only; every register, snapshot included, has a reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         snapshot  <= '0;
         idx       <= '0;
         byte_num  <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
         overrun   <= 1'b0;
`ifdef PERF_READER_CHECKSUM_EN
         checksum  <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (snapshot_req) begin
                  snapshot  <= count_in;
                  overrun   <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= HEADER_BYTE;
                  out_last  <= 1'b0;
                  state     <= HEADER;
`ifdef PERF_READER_CHECKSUM_EN
                  checksum  <= 8'h00;
`endif
               end
            end
            HEADER: begin
               if (xfer) begin
                  idx      <= '0;
                  byte_num <= '0;
                  out_data <= nxt_data;
                  out_last <= nxt_last;
                  state    <= DATA;
`ifdef PERF_READER_CHECKSUM_EN
                  checksum <= checksum ^ out_data;
`endif
               end
            end
            DATA: begin
               if (xfer) begin
`ifdef PERF_READER_CHECKSUM_EN
                  checksum <= checksum ^ out_data;
`endif
                  if (last_data) begin
`ifdef PERF_READER_CHECKSUM_EN
                     out_data <= checksum ^ out_data;
                     out_last <= 1'b1;
                     state    <= CKSUM;
`else
                     out_valid <= 1'b0;
                     out_data  <= 8'h00;
                     out_last  <= 1'b0;
                     idx       <= '0;
                     byte_num  <= '0;
                     state     <= IDLE;
`endif
                  end else begin
                     idx      <= nxt_idx;
                     byte_num <= nxt_byte;
                     out_data <= nxt_data;
                     out_last <= nxt_last;
                  end
               end
            end
`ifdef PERF_READER_CHECKSUM_EN
            CKSUM: begin
               if (xfer) begin
                  out_valid <= 1'b0;
                  out_data  <= 8'h00;
                  out_last  <= 1'b0;
                  idx       <= '0;
                  byte_num  <= '0;
                  state     <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase

         // A request is only honoured from IDLE; anything else is dropped and flagged.
         if (snapshot_req && state != IDLE)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader; frame length follows PERF_READER_CHECKSUM_EN.
module tb_perf_counter_reader;
   import perf_pkg::*;

   localparam int NUM    = DEFAULT_NUM_COUNTERS;
   localparam int CW     = 32;
   localparam int BUDGET = 2000;
`ifdef PERF_READER_CHECKSUM_EN
   localparam int FRAME_LEN = 2 + 4*NUM;
`else
   localparam int FRAME_LEN = 1 + 4*NUM;
`endif

   logic              clk          = 1'b0;
   logic              reset        = 1'b1;
   logic [NUM*CW-1:0] count_in     = '0;
   logic              snapshot_req = 1'b0;
   logic              out_ready    = 1'b0;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_last;
   logic              busy;
   logic              overrun;

   int         n_checks   = 0;
   int         n_pass     = 0;
   int         stall_errs = 0;
   logic [7:0] got[$];
   logic       got_last[$];
   logic [7:0] exp_q[$];

   perf_counter_reader #(
      .NUM_COUNTERS (NUM),
      .COUNT_W      (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .count_in     (count_in),
      .snapshot_req (snapshot_req),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
   endtask

   function automatic logic [7:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 8'hxx;
   endfunction

   function automatic void build_exp(input logic [NUM*CW-1:0] c);
      logic [7:0] x;
      logic [7:0] v;
      x = HEADER_BYTE;
      exp_q.delete();
      exp_q.push_back(HEADER_BYTE);
      for (int i = 0; i < NUM; i++) begin
         for (int b = 0; b < CW/8; b++) begin
            v = c[i*CW + b*8 +: 8];
            exp_q.push_back(v);
            x = x ^ v;
         end
      end
`ifdef PERF_READER_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endfunction

   // Called on a negedge: request a snapshot and confirm the header shows one cycle later.
   task automatic start_frame(input string tag);
      snapshot_req = 1'b1;
      @(negedge clk);
      snapshot_req = 1'b0;
      check({tag, "_first_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_header"}, 32'(out_data), 32'(HEADER_BYTE));
   endtask

   // Called on a negedge: drives out_ready and records bytes until out_last transfers,
   // stop_after bytes have transferred, or the cycle budget runs out.
   task automatic capture(input bit rand_ready, input int stop_after,
                          input int req_at, input bit req_on_last);
      int         cycles;
      bit         stalled;
      bit         done;
      bit         pulsed;
      logic [7:0] hold_d;
      logic       hold_l;
      cycles = 0; stalled = 0; done = 0; pulsed = 0;
      hold_d = 8'h00; hold_l = 1'b0;
      got.delete(); got_last.delete(); stall_errs = 0;
      while (1) begin
         cycles++;
         if (cycles > BUDGET) begin
            check("timeout", 32'(cycles), 32'(BUDGET));
            break;
         end
         if (stalled && (out_data !== hold_d || out_last !== hold_l)) stall_errs++;
         snapshot_req = 1'b0;
         if (done || got.size() == stop_after) break;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!pulsed && req_at >= 0 && got.size() == req_at) begin
            snapshot_req = 1'b1;
            pulsed       = 1;
            count_in     = ~count_in;
         end
         if (req_on_last && out_valid && out_last && out_ready) snapshot_req = 1'b1;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_last.push_back(out_last);
            stalled = 0;
            done    = out_last;
         end else begin
            stalled = out_valid;
            hold_d  = out_data;
            hold_l  = out_last;
         end
         @(negedge clk);
      end
      snapshot_req = 1'b0;
   endtask

   task automatic compare_frame(input string tag);
      check({tag, "_len"}, 32'(got.size()), 32'(FRAME_LEN));
      for (int i = 0; i < got.size() && i < FRAME_LEN; i++) begin
         check($sformatf("%s_byte%0d", tag, i + 1), 32'(got[i]), 32'(exp_q[i]));
         check($sformatf("%s_last%0d", tag, i + 1), 32'(got_last[i]), 32'(i == FRAME_LEN - 1));
      end
   endtask

   task automatic load_pattern();
      count_in = '0;
      count_in[int'(CNT_ADD)*CW +: CW] = 32'h1122_3344;
      count_in[int'(CNT_J)*CW   +: CW] = 32'hDEAD_BEEF;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_data", 32'(out_data), 32'(0));
      check("rst_last", 32'(out_last), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      reset = 1'b0;
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'(0));

      // All-zero counters, consumer always ready.
      build_exp(count_in);
      start_frame("zero");
      capture(0, -1, -1, 0);
      compare_frame("zero");
      check("zero_busy_after", 32'(busy), 32'(0));
      check("zero_valid_after", 32'(out_valid), 32'(0));
      check("zero_overrun", 32'(overrun), 32'(0));

      // ADD and J counters set, hand-computed byte positions.
      load_pattern();
      build_exp(count_in);
      start_frame("pat");
      capture(0, -1, -1, 0);
      compare_frame("pat");
      check("pat_b2", 32'(got_at(1)), 32'h44);
      check("pat_b3", 32'(got_at(2)), 32'h33);
      check("pat_b4", 32'(got_at(3)), 32'h22);
      check("pat_b5", 32'(got_at(4)), 32'h11);
      check("pat_b70", 32'(got_at(69)), 32'hEF);
      check("pat_b71", 32'(got_at(70)), 32'hBE);
      check("pat_b72", 32'(got_at(71)), 32'hAD);
      check("pat_b73", 32'(got_at(72)), 32'hDE);
`ifdef PERF_READER_CHECKSUM_EN
      check("pat_cksum", 32'(got_at(73)), 32'hC3);
`endif

      // Same frame with a stalling consumer.
      start_frame("rnd");
      capture(1, -1, -1, 0);
      compare_frame("rnd");
      check("rnd_stall_stable", 32'(stall_errs), 32'(0));

      // Request mid-frame plus count change: frame unchanged, overrun set.
      start_frame("ovr");
      capture(0, -1, 9, 0);
      compare_frame("ovr");
      check("ovr_flag", 32'(overrun), 32'(1));
      check("ovr_busy_after", 32'(busy), 32'(0));

      // Accepted request clears overrun; a request on the final byte is dropped.
      build_exp(count_in);
      start_frame("ovr2");
      check("ovr2_cleared", 32'(overrun), 32'(0));
      capture(0, -1, -1, 1);
      compare_frame("ovr2");
      check("lastreq_overrun", 32'(overrun), 32'(1));
      check("lastreq_busy", 32'(busy), 32'(0));
      @(negedge clk);
      check("lastreq_no_start", 32'(out_valid), 32'(0));

      // Reset in the middle of a frame.
      load_pattern();
      build_exp(count_in);
      start_frame("abort");
      capture(0, 30, -1, 0);
      check("abort_count", 32'(got.size()), 32'(30));
      reset = 1'b1;
      #1;
      check("abort_valid", 32'(out_valid), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_last", 32'(out_last), 32'(0));
      check("abort_overrun", 32'(overrun), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("abort_quiet%0d", i), 32'(out_valid), 32'(0));
      end
      start_frame("post");
      capture(0, -1, -1, 0);
      compare_frame("post");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/perf_counter_reader.md
PERF_COUNTER_READER -- requirements
Module: perf_counter_reader

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 18, meaning the number of 32-bit instruction counters captured.
REQ-002 SHALL have parameter COUNT_W, default 32, meaning the width of each counter; it SHALL be a multiple of 8.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port count_in  input  NUM_COUNTERS x COUNT_W  live counter values, index 0..17 = ADD, SUB, ADDI, ADD_FP, MUL_FP, VADD_FP, VMUL_FP, VSUM_FP, VSET_FP, SW, LW, SW_FP, LW_FP, VST, VLD, BEQ, BLT, J.
REQ-006 SHALL have port snapshot_req  input  1  single-cycle request to capture and stream all counters.
REQ-007 SHALL have port out_ready  input  1  consumer ready for a byte.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-009 SHALL have port out_data  output  8  stream byte.
REQ-010 SHALL have port out_last  output  1  marks the final byte of a frame.
REQ-011 SHALL have port busy  output  1  a frame is in progress (state != IDLE).
REQ-012 SHALL have port overrun  output  1  sticky flag: a snapshot_req was dropped.

Function
REQ-013 SHALL implement FSM states IDLE, HEADER, DATA, CKSUM.
REQ-014 IDLE + snapshot_req: SHALL copy all count_in into an internal snapshot register on that edge, clear overrun, clear the running checksum, and go to HEADER.
REQ-015 out_valid SHALL be high in HEADER, DATA and CKSUM and low in IDLE; the first valid byte SHALL appear one cycle after the accepting edge.
REQ-016 A byte SHALL transfer only on a cycle with out_valid && out_ready; out_data and out_last SHALL stay stable while out_valid && !out_ready.
REQ-017 HEADER SHALL drive 0xA5; on transfer go to DATA with counter index 0, byte 0.
REQ-018 DATA SHALL drive byte b (LSB first) of snapshot[index]; on transfer b increments, wrapping 3->0 with index+1.
REQ-019 The last byte of index NUM_COUNTERS-1 SHALL transfer into CKSUM.
REQ-020 CKSUM SHALL drive the XOR of all transferred bytes (header included); on transfer go to IDLE.
REQ-021 A frame SHALL be 2 + 4*NUM_COUNTERS bytes (74 at default); out_last SHALL be high only on the final byte.
REQ-022 snapshot_req while busy, including on the cycle the final byte transfers, SHALL be ignored and SHALL set overrun.
REQ-023 count_in changes after capture SHALL NOT affect the frame in progress.
REQ-024 Index and byte counters SHALL be sized from NUM_COUNTERS and COUNT_W with no overflow.

Reset
REQ-025 While reset is high: state=IDLE, out_valid=0, out_data=0x00, out_last=0, busy=0, overrun=0, snapshot, checksum, index and byte counters all zero.
REQ-026 Reset mid-frame SHALL abort the frame immediately; no further bytes of it SHALL be emitted.

Configuration
REQ-027 Macro PERF_READER_CHECKSUM_EN defined: CKSUM state and checksum byte present, as in REQ-020/021.
REQ-028 Macro PERF_READER_CHECKSUM_EN undefined: no CKSUM state or checksum logic; frame is 1 + 4*NUM_COUNTERS bytes (73 at default); out_last on the last DATA byte, which returns the FSM to IDLE.

Structure
REQ-029 Package perf_pkg SHALL hold NUM_COUNTERS default, the header constant 0xA5, the FSM state enum and the counter-index enum (ADD..J).
REQ-030 A sub-module perf_byte_sel SHALL be a combinational select of the (index, byte) byte from the snapshot; all other logic SHALL stay in perf_counter_reader.

Verification
REQ-031 All counts 0, out_ready=1, one snapshot_req -> 74 consecutive bytes: A5, 72x00, A5; out_last only on byte 74; busy low the cycle after.
REQ-032 count_in[0]=0x11223344, count_in[17]=0xDEADBEEF, others 0 -> bytes 2..5 = 44 33 22 11, bytes 70..73 = EF BE AD DE, checksum = A5^44^33^22^11^EF^BE^AD^DE.
REQ-033 out_ready toggled pseudo-randomly 50% -> identical byte sequence to REQ-032; out_data/out_last constant during every stall.
REQ-034 snapshot_req at byte 10 of a frame, then count_in changed -> frame unchanged, overrun=1; next accepted snapshot_req clears overrun.
REQ-035 reset asserted at byte 30 -> out_valid=0 and busy=0 immediately; next snapshot_req yields a full, correct frame starting with A5.
REQ-036 PERF_READER_CHECKSUM_EN undefined, zero counts -> 73 bytes, out_last on byte 73, no checksum byte.
